// File: rtl/dvfs_seg_scan.sv
// Multiplexed 7-segment driver for DVFS telemetry; updates latch only at frame boundaries.
// Optional leading-zero blanking is enabled by defining DVFS_SEG_LZB_EN.
module dvfs_seg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [VW-1:0]         act_val, pend_val;
  logic [NUM_DIGITS-1:0] act_dp, pend_dp;
  logic                  pend_flag;

  logic                  last_idx, slot_end, frame_end, pre_frame_end;
  logic [NUM_DIGITS-1:0] lz;
  logic [3:0]            nib;
  logic                  cur_en, cur_dp, cur_lz;

  assign last_idx      = (idx == IW'(NUM_DIGITS - 1));
  assign slot_end      = (cnt == CW'(REFRESH_DIV - 1));
  assign frame_end     = slot_end && last_idx;
  // frame_done is registered one cycle early so it lands exactly on the wrap cycle
  assign pre_frame_end = (cnt == CW'(REFRESH_DIV - 2)) && last_idx;

  always_comb begin
    logic z;
    lz = '0;
    z  = 1'b1;
`ifdef DVFS_SEG_LZB_EN
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      z     = z && (act_val[4*i +: 4] == 4'd0);
      lz[i] = z;
    end
`else
    z = 1'b0;
`endif
  end

  always_comb begin
    nib    = '0;
    cur_en = 1'b0;
    cur_dp = 1'b0;
    cur_lz = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib    = act_val[4*i +: 4];
        cur_en = digit_en[i];
        cur_dp = act_dp[i];
        cur_lz = lz[i];
      end
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      act_val    <= '0;
      act_dp     <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_flag  <= 1'b0;
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      cnt        <= slot_end ? '0 : cnt + CW'(1);
      frame_done <= pre_frame_end;
      if (slot_end) idx <= last_idx ? '0 : idx + IW'(1);

      if (frame_end) begin
        if (load) begin
          act_val <= value;
          act_dp  <= dp_in;
        end else if (pend_flag) begin
          act_val <= pend_val;
          act_dp  <= pend_dp;
        end
        pend_flag <= 1'b0;
      end else if (load) begin
        pend_val  <= value;
        pend_dp   <= dp_in;
        pend_flag <= 1'b1;
      end

      // Anti-ghost: anodes stay off for the first cycles of every slot
      if (cnt < CW'(BLANK_CYCLES) || !cur_en || cur_lz) begin
        an  <= '1;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end else begin
        an  <= ~(NUM_DIGITS'(1) << idx);
        seg <= hex7(nib);
        dp  <= ~cur_dp;
      end
    end
  end

endmodule

// File: tb/tb_dvfs_seg_scan.sv
// Randomised bench for dvfs_seg_scan against a frame-position reference model.
module tb_dvfs_seg_scan;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  dp_in = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  dvfs_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .digit_en(digit_en),
    .dp_in(dp_in), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] hex_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int          pos;
  logic [15:0] act_v, pend_v;
  logic [3:0]  act_dp, pend_dp;
  bit          pend_f;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_fd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    pos = 0; act_v = '0; act_dp = '0; pend_v = '0; pend_dp = '0; pend_f = 0;
    exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
  endtask

  // Predicts outputs after the coming edge from the frame position before it.
  task automatic model_edge();
    int slot, d;
    bit dark;
    logic [3:0] n;
    slot = pos % RD;
    d    = (pos / RD) % ND;
    n    = act_v[4*d +: 4];
    dark = (slot < BC) || !digit_en[d];
`ifdef DVFS_SEG_LZB_EN
    if (d > 0 && (act_v >> (4*d)) == 16'd0) dark = 1;
`endif
    if (dark) begin
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
    end else begin
      exp_an = ~(4'b0001 << d); exp_seg = hex_lut[n]; exp_dp = ~act_dp[d];
    end
    if (pos % FRAME == FRAME - 1) begin
      if (load) begin
        act_v = value; act_dp = dp_in;
      end else if (pend_f) begin
        act_v = pend_v; act_dp = pend_dp;
      end
      pend_f = 0;
    end else if (load) begin
      pend_v = value; pend_dp = dp_in; pend_f = 1;
    end
    pos++;
    exp_fd = (pos % FRAME == FRAME - 1);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      model_edge();
      @(posedge clk);
      @(negedge clk);
      chk("an", 32'(an), 32'(exp_an));
      chk("seg", 32'(seg), 32'(exp_seg));
      chk("dp", 32'(dp), 32'(exp_dp));
      chk("frame_done", 32'(frame_done), 32'(exp_fd));
      chk("an_single_low", 32'($countones(~an) <= 1), 32'd1);
    end
  endtask

  task automatic pulse(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic wait_frame_pos(input int t);
    for (int i = 0; i < 2 * FRAME && (pos % FRAME) != t; i++) step(1);
    if ((pos % FRAME) != t) begin
      errors++;
      $display("FAIL wait_pos: got %0d expected %0d", pos % FRAME, t);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_dp"}, 32'(dp), 32'd1);
    chk({tag, "_fd"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    step(40);

    wait_frame_pos(10);
    pulse(16'h3A2F, 4'h0);
    step(70);

    wait_frame_pos(3);
    pulse(16'h1111, 4'h0);
    step(5);
    pulse(16'h2222, 4'h0);
    step(70);

    wait_frame_pos(FRAME - 1);
    chk("fd_at_load", 32'(frame_done), 32'd1);
    pulse(16'h0003, 4'h0);
    step(40);

    digit_en = 4'b0101;
    pulse(16'h1234, 4'b0001);
    step(80);

    for (int i = 0; i < 400; i++) begin
      value    = 16'($urandom);
      load     = ($urandom_range(0, 7) == 0);
      digit_en = 4'($urandom);
      dp_in    = 4'($urandom);
      step(1);
    end
    load = 1'b0;

    digit_en = 4'hF;
    wait_frame_pos(3);
    pulse(16'hBEEF, 4'hF);
    step(1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    check_reset_outputs("held_rst");
    rst_n = 1'b1;
    step(70);

    wait_frame_pos(8);
    pulse(16'h0030, 4'h0);
    step(70);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
